// File: rtl/lut_serial_loader_if.sv
// Handshake and serial-line bundle between a table source and lut_serial_loader.
interface lut_serial_loader_if #(
    parameter int OUT_WIDTH = 4
);
    logic                 start;
    logic                 abort;
    logic                 in_valid;
    logic [OUT_WIDTH-1:0] in_data;
    logic                 in_ready;
    logic                 sdo;
    logic                 cs_n_o;
    logic                 busy;
    logic                 done;
    logic [OUT_WIDTH-1:0] checksum;

    modport master (
        output start, abort, in_valid, in_data,
        input  in_ready, sdo, cs_n_o, busy, done, checksum
    );

    modport slave (
        input  start, abort, in_valid, in_data,
        output in_ready, sdo, cs_n_o, busy, done, checksum
    );
endinterface

// File: rtl/lut_serial_loader.sv
// Serialises 2**IN_WIDTH table words MSB-first into a serial-load LUT shift register.
// Define LUT_LOADER_CHECKSUM_EN to build the XOR accumulator behind the checksum port.
module lut_serial_loader #(
    parameter int IN_WIDTH  = 4,
    parameter int OUT_WIDTH = 4
) (
    input logic              clk,
    input logic              rst_n,
    lut_serial_loader_if.slave bus
);
    localparam int ENTRIES = 2 ** IN_WIDTH;
    localparam int BW      = (OUT_WIDTH > 1) ? $clog2(OUT_WIDTH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_SHIFT, S_DONE} state_t;

    state_t               r_state;
    state_t               w_next;
    logic [OUT_WIDTH-1:0] r_shreg;
    logic [BW-1:0]        r_bit_cnt;
    logic [IN_WIDTH-1:0]  r_word_cnt;
    logic                 r_sdo;
    logic                 r_cs_n;
    logic                 w_in_ready;
    logic                 w_busy;
    logic                 w_done;
    logic                 w_accept;
    logic                 w_last_bit;
    logic                 w_last_word;

    assign w_accept    = (r_state == S_WAIT) && bus.in_valid;
    assign w_last_bit  = (r_bit_cnt == BW'(OUT_WIDTH - 1));
    assign w_last_word = (r_word_cnt == IN_WIDTH'(ENTRIES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (bus.abort) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (bus.start) w_next = S_WAIT;
                S_WAIT:  if (w_accept)  w_next = S_SHIFT;
                S_SHIFT: if (w_last_bit) w_next = w_last_word ? S_DONE : S_WAIT;
                S_DONE:  w_next = S_IDLE;
                default: w_next = S_IDLE;
            endcase
        end
    end

    always_comb begin
        w_in_ready = (r_state == S_WAIT);
        w_busy     = (r_state != S_IDLE);
        w_done     = (r_state == S_DONE);
    end

    // The serial line leads the LUT by one edge: bit k is driven on edge Ek and sampled on Ek+1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shreg    <= '0;
            r_bit_cnt  <= '0;
            r_word_cnt <= '0;
            r_sdo      <= 1'b0;
            r_cs_n     <= 1'b1;
        end else if (bus.abort) begin
            r_sdo  <= 1'b0;
            r_cs_n <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: if (bus.start) r_word_cnt <= '0;
                S_WAIT: begin
                    if (w_accept) begin
                        r_sdo     <= bus.in_data[OUT_WIDTH-1];
                        r_shreg   <= bus.in_data << 1;
                        r_bit_cnt <= '0;
                        r_cs_n    <= 1'b0;
                    end
                end
                S_SHIFT: begin
                    r_sdo     <= r_shreg[OUT_WIDTH-1];
                    r_shreg   <= r_shreg << 1;
                    r_bit_cnt <= r_bit_cnt + 1'b1;
                    if (w_last_bit) begin
                        r_cs_n <= 1'b1;
                        // Hold at the last index so the count never wraps inside a session.
                        if (!w_last_word) r_word_cnt <= r_word_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef LUT_LOADER_CHECKSUM_EN
    logic [OUT_WIDTH-1:0] r_checksum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                  r_checksum <= '0;
        else if (bus.abort)                          r_checksum <= r_checksum;
        else if ((r_state == S_IDLE) && bus.start)   r_checksum <= '0;
        else if (w_accept)                           r_checksum <= r_checksum ^ bus.in_data;
    end

    assign bus.checksum = r_checksum;
`else
    assign bus.checksum = '0;
`endif

    assign bus.in_ready = w_in_ready;
    assign bus.busy     = w_busy;
    assign bus.done     = w_done;
    assign bus.sdo      = r_sdo;
    assign bus.cs_n_o   = r_cs_n;
endmodule

// File: tb/tb_lut_serial_loader.sv
// Directed bench for lut_serial_loader with a behavioural model of the attached LUT shift register.
module tb_lut_serial_loader;
    logic clk = 1'b0;
    logic rst_n;
    int   n_chk = 0;
    int   n_err = 0;

    lut_serial_loader_if #(.OUT_WIDTH(4)) bus ();

    lut_serial_loader #(.IN_WIDTH(4), .OUT_WIDTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Attached LUT: shifts sdo in while cs_n is low.
    logic [63:0] lut = '0;
    int          lo_edges = 0;
    int          done_cnt = 0;
    always @(posedge clk) begin
        if (!bus.cs_n_o) begin
            lut      <= {lut[62:0], bus.sdo};
            lo_edges <= lo_edges + 1;
        end
        if (bus.done) done_cnt <= done_cnt + 1;
    end

    logic [3:0] wl [16];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Runs a full session from IDLE with in_valid held high; returns the cycle of done (start cycle = 1).
    task automatic full_load(output int dcyc, output logic [3:0] dsum);
        int  k;
        logic acc;
        dcyc = 0;
        dsum = '0;
        k = 0;
        bus.start    = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = wl[0];
        for (int n = 1; n <= 300 && dcyc == 0; n++) begin
            @(negedge clk);
            if (bus.done) begin
                dcyc = n;
                dsum = bus.checksum;
            end
            acc = bus.in_ready && bus.in_valid;
            @(posedge clk);
            #1;
            bus.start = 1'b0;
            if (acc) begin
                k++;
                if (k < 16) bus.in_data = wl[k];
                else        bus.in_valid = 1'b0;
            end
        end
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
    endtask

    initial begin
        int         lo0;
        int         dc0;
        int         dcyc;
        logic [3:0] dsum;
        logic [3:0] bits;
        logic [3:0] exp_sum;

        rst_n        = 1'b0;
        bus.start    = 1'b0;
        bus.abort    = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        #12;
        chk("rst_cs_n",     32'(bus.cs_n_o),   32'd1);
        chk("rst_sdo",      32'(bus.sdo),      32'd0);
        chk("rst_busy",     32'(bus.busy),     32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("rst_done",     32'(bus.done),     32'd0);
        chk("rst_checksum", 32'(bus.checksum), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(10);
        chk("idle_busy",     32'(bus.busy),     32'd0);
        chk("idle_in_ready", 32'(bus.in_ready), 32'd0);

        // Single word 0x9: bit order and cs_n window.
        bus.start = 1'b1;
        step(1);
        bus.start = 1'b0;
        chk("sw_wait_ready", 32'(bus.in_ready), 32'd1);
        chk("sw_wait_cs_n",  32'(bus.cs_n_o),   32'd1);
        bus.in_valid = 1'b1;
        bus.in_data  = 4'h9;
        step(1);
        bus.in_valid = 1'b0;
        lo0  = lo_edges;
        bits = 4'h9;
        for (int b = 3; b >= 0; b--) begin
            chk($sformatf("sw_sdo%0d", b), 32'(bus.sdo), 32'(bits[b]));
            chk($sformatf("sw_cs%0d", b),  32'(bus.cs_n_o), 32'd0);
            chk($sformatf("sw_rdy%0d", b), 32'(bus.in_ready), 32'd0);
            step(1);
        end
        chk("sw_cs_n_after",  32'(bus.cs_n_o),    32'd1);
        chk("sw_ready_after", 32'(bus.in_ready),  32'd1);
        chk("sw_edges",       32'(lo_edges - lo0), 32'd4);
        chk("sw_lut",         32'(lut[3:0]),       32'h9);
        bus.abort = 1'b1;
        step(1);
        bus.abort = 1'b0;
        chk("sw_abort_busy", 32'(bus.busy), 32'd0);

        // Backpressure: 7 idle cycles between words.
        bus.start = 1'b1;
        step(1);
        bus.start    = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = 4'h5;
        step(1);
        bus.in_valid = 1'b0;
        lo0 = lo_edges - 0;
        step(4 + 7);
        chk("bp_gap_cs_n",  32'(bus.cs_n_o),     32'd1);
        chk("bp_gap_edges", 32'(lo_edges - lo0), 32'd4);
        bus.in_valid = 1'b1;
        bus.in_data  = 4'hC;
        step(1);
        bus.in_valid = 1'b0;
        step(4);
        chk("bp_edges", 32'(lo_edges - lo0), 32'd8);
        chk("bp_lut",   32'(lut[7:0]),       32'h5C);
        bus.abort = 1'b1;
        step(1);
        bus.abort = 1'b0;

        // Abort after 3 words plus 2 bits; no done may follow.
        dc0 = done_cnt;
        lo0 = lo_edges;
        bus.start = 1'b1;
        step(1);
        bus.start = 1'b0;
        for (int w = 0; w < 3; w++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 4'(4'hA + w);
            step(1);
            bus.in_valid = 1'b0;
            step(4);
        end
        bus.in_valid = 1'b1;
        bus.in_data  = 4'hD;
        step(1);
        bus.in_valid = 1'b0;
        step(1);
        bus.abort = 1'b1;
        step(1);
        bus.abort = 1'b0;
        chk("ab_busy",  32'(bus.busy),       32'd0);
        chk("ab_cs_n",  32'(bus.cs_n_o),     32'd1);
        chk("ab_sdo",   32'(bus.sdo),        32'd0);
        chk("ab_edges", 32'(lo_edges - lo0), 32'd14);
        step(3);
        chk("ab_no_done", 32'(done_cnt - dc0), 32'd0);

        // Abort together with start in IDLE: stays idle.
        bus.start = 1'b1;
        bus.abort = 1'b1;
        step(1);
        bus.start = 1'b0;
        bus.abort = 1'b0;
        chk("ab_start_busy", 32'(bus.busy), 32'd0);

        // Full load, entry 15 first, in_valid held high.
        for (int i = 0; i < 16; i++) wl[i] = 4'(15 - i);
        dc0 = done_cnt;
        lo0 = lo_edges;
        full_load(dcyc, dsum);
        chk("fl_done_cycle", 32'(dcyc),            32'd82);
        chk("fl_done_cnt",   32'(done_cnt - dc0),  32'd1);
        chk("fl_edges",      32'(lo_edges - lo0),  32'd64);
        chk("fl_checksum",   32'(dsum),            32'd0);
        chk("fl_busy_after", 32'(bus.busy),        32'd0);
        for (int i = 0; i < 16; i++)
            chk($sformatf("fl_lut%0d", i), 32'(lut[i*4 +: 4]), 32'(i));
        chk("fl_sel_a", 32'(lut[43:40]), 32'hA);

        // Checksum session: 1,2,4,8 then zeros.
        for (int i = 0; i < 16; i++) wl[i] = 4'h0;
        wl[0] = 4'h1;
        wl[1] = 4'h2;
        wl[2] = 4'h4;
        wl[3] = 4'h8;
`ifdef LUT_LOADER_CHECKSUM_EN
        exp_sum = 4'hF;
`else
        exp_sum = 4'h0;
`endif
        full_load(dcyc, dsum);
        chk("ck_done_cycle", 32'(dcyc), 32'd82);
        chk("ck_at_done",    32'(dsum), 32'(exp_sum));
        step(2);
        chk("ck_stable",     32'(bus.checksum), 32'(exp_sum));
        chk("ck_lut15",      32'(lut[63:60]),   32'h1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/lut_serial_loader.md
# lut_serial_loader

Upstream feeder for the serial-load LUT. Accepts table entries one word at a time over a valid/ready handshake and serialises each word MSB-first onto a bit line, with an active-low chip select, in the exact order the LUT's shift register expects. A complete table load takes 2**IN_WIDTH words. The block pulses `done` when the load is complete and supports abort mid-load.

## Interface
- `IN_WIDTH`, default 4: LUT select width. ENTRIES = 2**IN_WIDTH.
- `OUT_WIDTH`, default 4: LUT entry width, in bits per word.
- `clk`, input, 1: clock. Shared with the LUT shift register.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `start`, input, 1: begins a load session. Sampled in IDLE only.
- `abort`, input, 1: cancels the session from any state.
- `in_valid`, input, 1: `in_data` is valid.
- `in_data`, input, OUT_WIDTH: table entry. Supplied highest index first (entry ENTRIES-1 first, entry 0 last).
- `in_ready`, output, 1: loader can accept a word.
- `sdo`, output, 1: serial data to the LUT `d`.
- `cs_n_o`, output, 1: active-low shift enable to the LUT `cs_n`.
- `busy`, output, 1: session in progress.
- `done`, output, 1: one-cycle pulse when the load is complete.
- `checksum`, output, OUT_WIDTH: XOR of the accepted words (see Configuration).

## Operation
- Registers:
  - state: one of IDLE, WAIT, SHIFT, DONE.
  - shreg: OUT_WIDTH bits.
  - bit_cnt: clog2(OUT_WIDTH) bits.
  - word_cnt: IN_WIDTH bits.
  - sdo, cs_n_o, checksum.
- Reset values: state=IDLE, `sdo`=0, `cs_n_o`=1, `in_ready`=0, `busy`=0, `done`=0, `checksum`=0, all counters 0.
- IDLE:
  - `start`=1 → WAIT. Clears word_cnt and checksum.
  - `start` is ignored in all other states.
- WAIT:
  - `in_ready`=1 and `cs_n_o`=1.
  - On `in_valid`&&`in_ready` → SHIFT. On that edge: `sdo`<=in_data[MSB], shreg<=in_data<<1, bit_cnt<=0, `cs_n_o`<=0, checksum^=in_data.
- SHIFT:
  - `in_ready`=0 and `cs_n_o`=0.
  - Each edge: `sdo`<=shreg[MSB], shreg<<=1, bit_cnt++.
  - On the edge where bit_cnt==OUT_WIDTH-1: `cs_n_o`<=1, and word_cnt++.
  - If word_cnt==ENTRIES-1 the next state is DONE; otherwise it is WAIT.
- DONE: `done`=1 for exactly one cycle, then IDLE.
- `busy` = (state != IDLE). `in_ready` is combinational from state.
- abort:
  - Any state → IDLE on the next edge, with `cs_n_o`<=1 and `sdo`<=0. No `done` pulse.
  - Words already shifted stay in the LUT. Software must reload.
  - `abort` and `start` together in IDLE: abort wins and the block stays in IDLE.
- Result: exactly OUT_WIDTH edges with `cs_n_o`=0 per accepted word, and exactly ENTRIES×OUT_WIDTH edges per completed session. After the session, entry i sits at LUT bits [(i+1)·OUT_WIDTH-1 -: OUT_WIDTH].
- word_cnt does not wrap within a session. A session always ends in DONE or in abort.

## Timing
- Word accepted at edge E0. `cs_n_o` is low after E0 through E0+OUT_WIDTH-1. The LUT samples bits at edges E1..E(OUT_WIDTH), MSB first.
- `in_ready` re-asserts in the cycle after E(OUT_WIDTH). Minimum word period is OUT_WIDTH+1 cycles.
- Minimum full load for the defaults: 1 (start) + 16×5 cycles, followed by the `done` cycle.
- `in_valid` may be held high across words. A word is consumed only in a cycle where `in_ready`=1.
- Reset asserted mid-SHIFT: `cs_n_o` goes to 1 immediately (asynchronous), and the LUT stops shifting.

## Configuration
- `LUT_LOADER_CHECKSUM_EN` defined:
  - `checksum` accumulates the XOR of every accepted `in_data`.
  - It is cleared on `start` and is stable from the `done` cycle until the next `start`.
- `LUT_LOADER_CHECKSUM_EN` undefined:
  - The `checksum` port remains but is tied to 0, and no accumulator logic exists.

## Test plan
- Reset: `rst_n`=0 → `cs_n_o`=1, `sdo`=0, `busy`=0, `in_ready`=0, `done`=0. Release; with `start`=0 for 10 cycles, state stays IDLE.
- Full load: start, then words 0xF,0xE,…,0x0 (entry 15 first) with `in_valid` held high.
  - `done` pulses at cycle 82.
  - Attached LUT reads sel=i → out=i for all i; sel=0xA → 0xA.
- Single-word bit order: accept 0x9 → `sdo` sequence 1,0,0,1 on edges E1..E4 with `cs_n_o`=0; `cs_n_o`=1 at E5; `in_ready`=1 after E4.
- Backpressure: `in_valid` low for 7 cycles between words → `cs_n_o` stays 1 and no LUT shifting occurs; bit count remains 4 per word.
- Abort after 3 words plus 2 bits → IDLE next edge, `cs_n_o`=1, no `done`. A new start followed by 16 words completes normally.
- With `LUT_LOADER_CHECKSUM_EN`: words 0x1,0x2,0x4,0x8,then 12×0x0 → `checksum`=0xF at `done`. Without the macro, `checksum`=0 throughout.
